// File: rtl/osc_timebase_rstgen.sv
// osc_timebase_rstgen: fabric reset sequencer and system timebase for the
// 1 MHz RC oscillator domain.
//
// After the synchronised lock indication is seen, SYS_RESETN is held low for
// RST_HOLD_CYCLES cycles and then released. While released, the block produces
// a 1 ms strobe, a 1 s strobe and a heartbeat square wave. Losing lock
// re-asserts SYS_RESETN and clears the timebase.
//
// Optional feature: define OSC_TIMEBASE_UPTIME_EN to add the UPTIME_S seconds
// counter and its output port. Without the macro, neither the port nor the
// counter exists.
//
// Ports:
//   CLK         in   1   oscillator clock
//   RESETN      in   1   asynchronous active-low reset
//   LOCK_IN     in   1   asynchronous lock/ready indication
//   SYS_RESETN  out  1   registered fabric reset, active-low
//   TICK_1MS    out  1   one-cycle strobe once per ms
//   TICK_1S     out  1   one-cycle strobe once per s
//   HEARTBEAT   out  1   toggles every HEARTBEAT_MS ms
//   UPTIME_S    out  32  seconds since SYS_RESETN rose (OSC_TIMEBASE_UPTIME_EN only)

module osc_timebase_rstgen #(
    parameter int unsigned CLK_FREQ_HZ     = 1000000,
    parameter int unsigned RST_HOLD_CYCLES = 1000,
    parameter int unsigned HEARTBEAT_MS    = 500
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        LOCK_IN,
    output logic        SYS_RESETN,
    output logic        TICK_1MS,
    output logic        TICK_1S,
`ifdef OSC_TIMEBASE_UPTIME_EN
    output logic        HEARTBEAT,
    output logic [31:0] UPTIME_S
`else
    output logic        HEARTBEAT
`endif
);

    localparam int unsigned MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned HB_W   = $clog2(HEARTBEAT_MS + 1);
    localparam int unsigned S_W    = 10;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              lock_meta;
    logic              lock_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [S_W-1:0]    s_cnt;
    logic [HB_W-1:0]   hb_cnt;

    logic hold_done;
    logic run_next;
    logic run_cont;
    logic ms_wrap;
    logic s_wrap;
    logic hb_wrap;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK_IN;
            lock_s    <= lock_meta;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= WAIT_LOCK;
        end else begin
            state <= next_state;
        end
    end

    assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1));

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: if (lock_s) next_state = HOLD;
            HOLD: begin
                if (!lock_s)        next_state = WAIT_LOCK;
                else if (hold_done) next_state = RUN;
            end
            RUN:       if (!lock_s) next_state = WAIT_LOCK;
            default:   next_state = WAIT_LOCK;
        endcase
    end

    // Decodes feeding the output and counter registers. run_cont marks a
    // cycle that is in RUN and stays in RUN; only then does the timebase
    // advance, which keeps strobes off on the edge where lock is lost.
    always_comb begin
        run_next = 1'b0;
        run_cont = 1'b0;
        ms_wrap  = 1'b0;
        s_wrap   = 1'b0;
        hb_wrap  = 1'b0;
        run_next = (next_state == RUN);
        run_cont = (state == RUN) && run_next;
        ms_wrap  = run_cont && (ms_cnt == MS_W'(MS_DIV - 1));
        s_wrap   = (s_cnt == S_W'(999));
        hb_wrap  = (hb_cnt == HB_W'(HEARTBEAT_MS - 1));
    end

    // Reset hold counter and registered fabric reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hold_cnt   <= '0;
            SYS_RESETN <= 1'b0;
        end else begin
            if (state == HOLD && next_state == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
            SYS_RESETN <= run_next;
        end
    end

    // Timebase: ms divider, seconds divider, heartbeat.
    // The heartbeat advances on the registered 1 ms strobe, so it toggles
    // one cycle after the strobe that completes its period.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ms_cnt    <= '0;
            s_cnt     <= '0;
            hb_cnt    <= '0;
            TICK_1MS  <= 1'b0;
            TICK_1S   <= 1'b0;
            HEARTBEAT <= 1'b0;
        end else if (run_cont) begin
            ms_cnt   <= ms_wrap ? '0 : ms_cnt + MS_W'(1);
            TICK_1MS <= ms_wrap;
            TICK_1S  <= ms_wrap && s_wrap;
            if (ms_wrap) begin
                s_cnt <= s_wrap ? '0 : s_cnt + S_W'(1);
            end
            if (TICK_1MS) begin
                hb_cnt <= hb_wrap ? '0 : hb_cnt + HB_W'(1);
                if (hb_wrap) begin
                    HEARTBEAT <= ~HEARTBEAT;
                end
            end
        end else begin
            ms_cnt    <= '0;
            s_cnt     <= '0;
            hb_cnt    <= '0;
            TICK_1MS  <= 1'b0;
            TICK_1S   <= 1'b0;
            HEARTBEAT <= 1'b0;
        end
    end

`ifdef OSC_TIMEBASE_UPTIME_EN
    // Seconds since release; bumps the cycle after each 1 s strobe.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            UPTIME_S <= '0;
        end else if (!run_cont) begin
            UPTIME_S <= '0;
        end else if (TICK_1S) begin
            UPTIME_S <= UPTIME_S + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_osc_timebase_rstgen.sv
// Directed testbench for osc_timebase_rstgen with CLK_FREQ_HZ=10000 (10-cycle
// ms), RST_HOLD_CYCLES=10 and HEARTBEAT_MS=3.

module tb_osc_timebase_rstgen;

    logic        CLK;
    logic        RESETN;
    logic        LOCK_IN;
    logic        SYS_RESETN;
    logic        TICK_1MS;
    logic        TICK_1S;
    logic        HEARTBEAT;
`ifdef OSC_TIMEBASE_UPTIME_EN
    logic [31:0] UPTIME_S;
`endif

    int n_cmp;
    int n_err;

    osc_timebase_rstgen #(
        .CLK_FREQ_HZ    (10000),
        .RST_HOLD_CYCLES(10),
        .HEARTBEAT_MS   (3)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .LOCK_IN   (LOCK_IN),
        .SYS_RESETN(SYS_RESETN),
        .TICK_1MS  (TICK_1MS),
        .TICK_1S   (TICK_1S),
`ifdef OSC_TIMEBASE_UPTIME_EN
        .HEARTBEAT (HEARTBEAT),
        .UPTIME_S  (UPTIME_S)
`else
        .HEARTBEAT (HEARTBEAT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raise LOCK_IN now (just after an edge); SYS_RESETN must stay low for
    // 12 edges and be high after the 13th.
    task automatic expect_release(input string tag);
        logic exp;
        LOCK_IN = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp = (e == 13) ? 1'b1 : 1'b0;
            n_cmp++;
            if (SYS_RESETN !== exp) begin
                n_err++;
                $display("FAIL %s edge %0d: SYS_RESETN=%b required %b", tag, e, SYS_RESETN, exp);
            end
        end
    endtask

    // After a release, the first 1 ms strobe must land exactly on cycle 10.
    task automatic expect_first_tick(input string tag);
        logic exp;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = (c == 10) ? 1'b1 : 1'b0;
            n_cmp++;
            if (TICK_1MS !== exp) begin
                n_err++;
                $display("FAIL %s cycle %0d: TICK_1MS=%b required %b", tag, c, TICK_1MS, exp);
            end
        end
    endtask

    task automatic test_reset();
        RESETN  = 1'b0;
        LOCK_IN = 1'b0;
        repeat (3) tick();
        n_cmp += 4;
        if (SYS_RESETN !== 1'b0) begin n_err++; $display("FAIL reset SYS_RESETN: got %b required 0", SYS_RESETN); end
        if (TICK_1MS !== 1'b0)   begin n_err++; $display("FAIL reset TICK_1MS: got %b required 0", TICK_1MS); end
        if (TICK_1S !== 1'b0)    begin n_err++; $display("FAIL reset TICK_1S: got %b required 0", TICK_1S); end
        if (HEARTBEAT !== 1'b0)  begin n_err++; $display("FAIL reset HEARTBEAT: got %b required 0", HEARTBEAT); end
`ifdef OSC_TIMEBASE_UPTIME_EN
        n_cmp++;
        if (UPTIME_S !== 32'd0) begin n_err++; $display("FAIL reset UPTIME_S: got %0h required 0", UPTIME_S); end
`endif
        RESETN = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (SYS_RESETN !== 1'b0) begin n_err++; $display("FAIL no_lock SYS_RESETN: got %b required 0", SYS_RESETN); end
    endtask

    task automatic test_lock_seq();
        expect_release("lock_seq");
    endtask

    // Runs from the SYS_RESETN rise cycle through cycle 10000.
    task automatic test_tick_cadence();
        logic e_ms, e_s, e_hb;
        for (int c = 1; c <= 10000; c++) begin
            tick();
            e_ms = ((c % 10) == 0) ? 1'b1 : 1'b0;
            e_s  = (c == 10000) ? 1'b1 : 1'b0;
            e_hb = ((((c - 1) / 30) % 2) == 1) ? 1'b1 : 1'b0;
            n_cmp += 3;
            if (TICK_1MS !== e_ms) begin n_err++; $display("FAIL cadence TICK_1MS cycle %0d: got %b required %b", c, TICK_1MS, e_ms); end
            if (TICK_1S !== e_s)   begin n_err++; $display("FAIL cadence TICK_1S cycle %0d: got %b required %b", c, TICK_1S, e_s); end
            if (HEARTBEAT !== e_hb) begin n_err++; $display("FAIL cadence HEARTBEAT cycle %0d: got %b required %b", c, HEARTBEAT, e_hb); end
        end
    endtask

    // Continues from cycle 10000; drops lock at cycle 10005 (HEARTBEAT high,
    // next strobe due at 10010, which must be suppressed).
    task automatic test_lock_loss();
        logic e_sys;
        repeat (5) tick();
        LOCK_IN = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_sys = (e < 3) ? 1'b1 : 1'b0;
            n_cmp += 3;
            if (SYS_RESETN !== e_sys) begin n_err++; $display("FAIL loss SYS_RESETN edge %0d: got %b required %b", e, SYS_RESETN, e_sys); end
            if (HEARTBEAT !== e_sys)  begin n_err++; $display("FAIL loss HEARTBEAT edge %0d: got %b required %b", e, HEARTBEAT, e_sys); end
            if (TICK_1MS !== 1'b0)    begin n_err++; $display("FAIL loss TICK_1MS edge %0d: got %b required 0", e, TICK_1MS); end
        end
        expect_release("relock");
        expect_first_tick("relock_tick");
    endtask

    task automatic test_glitch();
        LOCK_IN = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (SYS_RESETN !== 1'b0) begin n_err++; $display("FAIL glitch_pre SYS_RESETN: got %b required 0", SYS_RESETN); end
        LOCK_IN = 1'b1;
        repeat (5) tick();
        LOCK_IN = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_cmp++;
            if (SYS_RESETN !== 1'b0) begin n_err++; $display("FAIL glitch SYS_RESETN edge %0d: got %b required 0", e, SYS_RESETN); end
        end
        expect_release("glitch_relock");
    endtask

    // Starts at a SYS_RESETN rise cycle; resets mid-count with HEARTBEAT high.
    task automatic test_async_reset();
        repeat (35) tick();
        n_cmp++;
        if (HEARTBEAT !== 1'b1) begin n_err++; $display("FAIL async_pre HEARTBEAT: got %b required 1", HEARTBEAT); end
        #3;
        RESETN = 1'b0;
        #1;
        n_cmp += 4;
        if (SYS_RESETN !== 1'b0) begin n_err++; $display("FAIL async SYS_RESETN: got %b required 0", SYS_RESETN); end
        if (HEARTBEAT !== 1'b0)  begin n_err++; $display("FAIL async HEARTBEAT: got %b required 0", HEARTBEAT); end
        if (TICK_1MS !== 1'b0)   begin n_err++; $display("FAIL async TICK_1MS: got %b required 0", TICK_1MS); end
        if (TICK_1S !== 1'b0)    begin n_err++; $display("FAIL async TICK_1S: got %b required 0", TICK_1S); end
        repeat (2) tick();
        RESETN = 1'b1;
        expect_release("async_restart");
        expect_first_tick("async_tick");
    endtask

`ifdef OSC_TIMEBASE_UPTIME_EN
    // Starts right after a release plus 10 cycles of first-tick check.
    task automatic test_uptime();
        LOCK_IN = 1'b0;
        repeat (6) tick();
        expect_release("uptime_release");
        repeat (30001) tick();
        n_cmp++;
        if (UPTIME_S !== 32'd3) begin n_err++; $display("FAIL uptime_3s: got %0d required 3", UPTIME_S); end
        force dut.UPTIME_S = 32'hFFFF_FFFF;
        #1;
        release dut.UPTIME_S;
        repeat (10000) tick();
        n_cmp++;
        if (UPTIME_S !== 32'd0) begin n_err++; $display("FAIL uptime_wrap: got %0h required 0", UPTIME_S); end
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        RESETN  = 1'b0;
        LOCK_IN = 1'b0;
        test_reset();
        test_lock_seq();
        test_tick_cadence();
        test_lock_loss();
        test_glitch();
        test_async_reset();
`ifdef OSC_TIMEBASE_UPTIME_EN
        test_uptime();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
